// File: rtl/reg_lock_scoreboard_pkg.sv
// Shared parameters, types and helpers for the launch-stage register lock scoreboard.
package maverickOne_pkg;

    localparam int NUM_REGS        = 32;
    localparam int NUM_WB_PORTS    = 2;
    localparam int NUM_OUTSTANDING = 4;

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_OUTSTANDING + 3);
    localparam int DEC_W  = $clog2(NUM_WB_PORTS + 1);

    typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

    typedef enum logic {SB_RUN, SB_DRAIN} sb_state_e;

    // Number of writeback ports retiring register idx this cycle; register 0 never retires.
    function automatic logic [DEC_W-1:0] count_wb_hits(
        input logic [NUM_WB_PORTS-1:0]             valid,
        input logic [NUM_WB_PORTS-1:0][REG_AW-1:0] rd,
        input logic [REG_AW-1:0]                   idx
    );
        logic [DEC_W-1:0] hits;
        hits = {DEC_W{1'b0}};
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (valid[p] && (rd[p] == idx) && (idx != {REG_AW{1'b0}})) begin
                hits = hits + {{(DEC_W-1){1'b0}}, 1'b1};
            end else begin
                hits = hits;
            end
        end
        return hits;
    endfunction

endpackage

// File: rtl/reg_lock_scoreboard_if.sv
// Launch handshake and writeback bus observed by the scoreboard.
interface reg_lock_scoreboard_if;
    import maverickOne_pkg::*;

    logic                                  launch_valid_i;
    logic                                  launch_ready_i;
    logic                                  launch_wr_en_i;
    reg_addr_t                             launch_rd_i;
    logic                                  launch_mem_i;
    logic [NUM_WB_PORTS-1:0]               wb_valid_i;
    logic [NUM_WB_PORTS-1:0][REG_AW-1:0]   wb_rd_i;
    logic                                  mem_done_i;

    modport master (
        output launch_valid_i, launch_ready_i, launch_wr_en_i, launch_rd_i,
               launch_mem_i, wb_valid_i, wb_rd_i, mem_done_i
    );

    modport slave (
        input  launch_valid_i, launch_ready_i, launch_wr_en_i, launch_rd_i,
               launch_mem_i, wb_valid_i, wb_rd_i, mem_done_i
    );

endinterface

// File: rtl/reg_lock_scoreboard_cntr.sv
// Saturating up/down outstanding-operation counter with a registered nonzero flag.
module reg_lock_cntr #(
    parameter int CW = 3,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          inc_i,
    input  logic [DW-1:0] dec_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int SW = CW + DW + 1;
    localparam logic [SW-1:0] MAX_EXT = SW'((1 << CW) - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          nonzero_q;
    logic [SW-1:0] sum_s;
    logic [SW-1:0] dec_s;
    logic [SW-1:0] diff_s;
    logic          ovf_s;
    logic          unf_s;

    // Net increment and decrement, clamping at zero and saturating at max.
    always_comb begin
        sum_s   = SW'(count_q) + SW'(inc_i);
        dec_s   = SW'(dec_i);
        diff_s  = sum_s - dec_s;
        ovf_s   = 1'b0;
        unf_s   = 1'b0;
        count_d = count_q;
        if (dec_s > sum_s) begin
            unf_s   = 1'b1;
            count_d = {CW{1'b0}};
        end else if (diff_s > MAX_EXT) begin
            ovf_s   = 1'b1;
            count_d = {CW{1'b1}};
        end else begin
            count_d = CW'(diff_s);
        end
    end

    // Counter state and its nonzero flag, both registered.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q   <= {CW{1'b0}};
            nonzero_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            nonzero_q <= (count_d != {CW{1'b0}});
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = nonzero_q;
    assign ovf_o     = ovf_s;
    assign unf_o     = unf_s;

endmodule

// File: rtl/reg_lock_scoreboard.sv
// Per-register lock and memory-busy tracking with a RUN/DRAIN sequencer for pipeline clears.
module reg_lock_scoreboard
    import maverickOne_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    clear_i,
    reg_lock_scoreboard_if.slave    bus,
    output logic [NUM_REGS-1:0]     locks_o,
    output logic                    mem_busy_o,
    output logic                    hold_o,
    output logic                    idle_o,
    output logic                    err_o
);

    localparam int NR = NUM_REGS;
    localparam int AW = REG_AW;
    localparam int CW = CNT_W;
    localparam int DW = DEC_W;

    localparam logic [0:0] ST_RUN   = 1'(SB_RUN);
    localparam logic [0:0] ST_DRAIN = 1'(SB_DRAIN);

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic                err_q;
    logic                err_d;

    logic                hs_s;
    logic                run_hs_s;
    logic [NR-1:0]       inc_s;
    logic [DW-1:0]       dec_s [NR];
    logic [NR-1:0]       nonzero_s;
    logic [NR-1:0]       ovf_s;
    logic [NR-1:0]       unf_s;
    logic [CW-1:0]       count_s [NR];
    logic                mem_inc_s;
    logic [DW-1:0]       mem_dec_s;
    logic                mem_nonzero_s;
    logic                mem_ovf_s;
    logic                mem_unf_s;
    logic [CW-1:0]       mem_count_s;
    logic                drain_done_s;

    assign hs_s     = bus.launch_valid_i && bus.launch_ready_i;
    assign run_hs_s = hs_s && (state_q == ST_RUN);

    // Decode launch and writeback traffic into per-register increments and decrements.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            inc_s[r] = 1'b0;
            dec_s[r] = {DW{1'b0}};
            if (r != 0) begin
                inc_s[r] = run_hs_s && bus.launch_wr_en_i && (bus.launch_rd_i == AW'(r));
                dec_s[r] = count_wb_hits(bus.wb_valid_i, bus.wb_rd_i, AW'(r));
            end else begin
                inc_s[r] = 1'b0;
                dec_s[r] = {DW{1'b0}};
            end
        end
    end

    assign mem_inc_s = run_hs_s && bus.launch_mem_i;
    assign mem_dec_s = DW'(bus.mem_done_i);

    for (genvar g = 0; g < NR; g++) begin : g_reg_cntr
        reg_lock_cntr #(.CW(CW), .DW(DW)) u_cntr (
            .clk_i     (clk_i),
            .srst_i    (srst_i),
            .inc_i     (inc_s[g]),
            .dec_i     (dec_s[g]),
            .count_o   (count_s[g]),
            .nonzero_o (nonzero_s[g]),
            .ovf_o     (ovf_s[g]),
            .unf_o     (unf_s[g])
        );
    end

    reg_lock_cntr #(.CW(CW), .DW(DW)) u_mem_cntr (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .inc_i     (mem_inc_s),
        .dec_i     (mem_dec_s),
        .count_o   (mem_count_s),
        .nonzero_o (mem_nonzero_s),
        .ovf_o     (mem_ovf_s),
        .unf_o     (mem_unf_s)
    );

    assign drain_done_s = !(|nonzero_s) && !mem_nonzero_s && !clear_i;

    // Sequencer: a clear parks the launcher in DRAIN until everything has retired.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Sticky error: counter saturation/underflow anywhere, or a launch accepted while draining.
    always_comb begin
        err_d = err_q || (|ovf_s) || (|unf_s) || mem_ovf_s || mem_unf_s ||
                (hs_s && (state_q == ST_DRAIN));
    end

    // Sequencer state and error flag registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign locks_o    = nonzero_s;
    assign mem_busy_o = mem_nonzero_s;
    assign idle_o     = !(|nonzero_s) && !mem_nonzero_s;
    assign hold_o     = (state_q == ST_DRAIN);
    assign err_o      = err_q;

endmodule
